// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned MAX_NUM_REQ = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping modulo N; returns both a one-hot pick and its index.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmitter.
// Optional mid-packet stall timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_last;
  logic               xfer;
  logic               timeout_hit;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign grant = grant_q;

  // Datapath mux keyed off the registered one-hot grant; zero while idle.
  always_comb begin
    tx_data    = '0;
    tx_valid   = 1'b0;
    owner_last = 1'b0;
    req_ready  = '0;
    if (state == BUSY) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          tx_data    = req_data[i*BYTE_W +: BYTE_W];
          tx_valid   = req_valid[i];
          owner_last = req_last[i];
        end
      end
      req_ready = grant_q & {NUM_REQ{tx_ready}};
    end
  end

  assign xfer = tx_valid & tx_ready;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    grant_nxt = grant_q;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = BUSY;
          owner_nxt = pick_idx;
          grant_nxt = pick;
        end
      end
      BUSY: begin
        if ((xfer && owner_last) || timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
      grant_q <= grant_nxt;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive BUSY cycle without a transfer.
  assign timeout_hit = (state == BUSY) && !xfer && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= timeout_hit;
      if (state != BUSY || xfer || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [7:0]        tx_data;
  logic              tx_valid, tx_ready, timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stall_cnt = 0;

  logic [8:0] src_q [NREQ][$];
  logic [7:0] got_q[$];
  logic [3:0] got_g[$];
  int         got_c[$];

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester sources and transfer monitor: inputs change at negedge only.
  initial begin
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_data[i*8 +: 8]  = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      if (stall_cnt > 0) begin
        tx_ready  = 1'b0;
        stall_cnt = stall_cnt - 1;
      end else begin
        tx_ready = 1'b1;
      end
      #1;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_g.push_back(grant);
        got_c.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_got();
    got_q.delete();
    got_g.delete();
    got_c.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    clear_got();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); #2;
      if (all_empty() && grant == 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic wait_got(input int count, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); #2;
      if (got_q.size() >= count) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp_d[3] = '{8'h41, 8'h42, 8'h0A};
    bit ok;
    clear_got();
    src_q[1].push_back({1'b0, 8'h41});
    src_q[1].push_back({1'b0, 8'h42});
    src_q[1].push_back({1'b1, 8'h0A});
    @(negedge clk); #2;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_latency_grant: got %b expected 0000", grant); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL single_idle_tx: got valid %b data %h expected 0 00", tx_valid, tx_data); end
    @(negedge clk); #2;
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant: got %b expected 0010", grant); end
    checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_first_data: got %h expected 41", tx_data); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_req_ready: got %b expected 0010", req_ready); end
    wait_drain(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL single_count: got %0d expected 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_d[k] || got_g[k] !== 4'b0010) begin
        failures++;
        $display("FAIL single_byte%0d: got %h/%b expected %h/0010", k, got_q[k], got_g[k], exp_d[k]);
      end
    end
    if (got_c.size() == 3) begin
      checks++; if (got_c[2] - got_c[0] != 2) begin failures++; $display("FAIL single_back_to_back: got span %0d expected 2", got_c[2] - got_c[0]); end
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d[6] = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hB0, 8'hB1};
    logic [3:0] exp_g[6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
    bit ok;
    apply_reset();
    src_q[0].push_back({1'b0, 8'hA0});
    src_q[0].push_back({1'b1, 8'hA1});
    src_q[0].push_back({1'b0, 8'hB0});
    src_q[0].push_back({1'b1, 8'hB1});
    src_q[2].push_back({1'b0, 8'hC0});
    src_q[2].push_back({1'b1, 8'hC1});
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL contention_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL contention_count: got %0d expected 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_d[k] || got_g[k] !== exp_g[k]) begin
        failures++;
        $display("FAIL contention_byte%0d: got %h/%b expected %h/%b", k, got_q[k], got_g[k], exp_d[k], exp_g[k]);
      end
    end
    if (got_c.size() == 6) begin
      checks++; if (got_c[2] - got_c[1] != 2) begin failures++; $display("FAIL contention_bubble1: got gap %0d expected 2", got_c[2] - got_c[1]); end
      checks++; if (got_c[4] - got_c[3] != 2) begin failures++; $display("FAIL contention_bubble2: got gap %0d expected 2", got_c[4] - got_c[3]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    bit ok;
    clear_got();
    src_q[2].push_back({1'b0, 8'h10});
    src_q[2].push_back({1'b0, 8'h11});
    src_q[2].push_back({1'b0, 8'h12});
    src_q[2].push_back({1'b1, 8'h13});
    wait_got(2, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_start: got timeout expected 2 bytes"); end
    stall_cnt = 5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      checks++;
      if (tx_data !== 8'h12 || tx_valid !== 1'b1 || req_ready !== 4'b0000 || grant !== 4'b0100) begin
        failures++;
        $display("FAIL bp_stall%0d: got data %h valid %b ready %b grant %b expected 12 1 0000 0100", k, tx_data, tx_valid, req_ready, grant);
      end
    end
    wait_drain(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_d[k]) begin failures++; $display("FAIL bp_byte%0d: got %h expected %h", k, got_q[k], exp_d[k]); end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] exp_d[6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h31, 8'h32};
    logic [3:0] exp_g[6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
    bit ok;
    clear_got();
    src_q[1].push_back({1'b0, 8'h21});
    src_q[1].push_back({1'b0, 8'h22});
    src_q[1].push_back({1'b0, 8'h23});
    src_q[1].push_back({1'b1, 8'h24});
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); #2;
      if (grant == 4'b0010) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL interleave_grant1: got %b expected 0010", grant); end
    src_q[3].push_back({1'b0, 8'h31});
    src_q[3].push_back({1'b1, 8'h32});
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL interleave_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL interleave_count: got %0d expected 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_d[k] || got_g[k] !== exp_g[k]) begin
        failures++;
        $display("FAIL interleave_byte%0d: got %h/%b expected %h/%b", k, got_q[k], got_g[k], exp_d[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_got();
    src_q[1].push_back({1'b1, 8'h55});
    wait_drain(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_pre_drain: got timeout expected idle"); end
    clear_got();
    src_q[2].push_back({1'b0, 8'h61});
    src_q[2].push_back({1'b0, 8'h62});
    src_q[2].push_back({1'b0, 8'h63});
    src_q[2].push_back({1'b1, 8'h64});
    wait_got(2, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_start: got timeout expected 2 bytes"); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    src_q[2].delete();
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rmid_grant: got %b expected 0000", grant); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rmid_tx_valid: got %b expected 0", tx_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_got();
    src_q[0].push_back({1'b1, 8'h50});
    src_q[3].push_back({1'b1, 8'h60});
    wait_drain(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_post_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL rmid_count: got %0d expected 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 8'h50 || got_g[0] !== 4'b0001) begin failures++; $display("FAIL rmid_favour0: got %h/%b expected 50/0001", got_q[0], got_g[0]); end
      checks++; if (got_q[1] !== 8'h60 || got_g[1] !== 4'b1000) begin failures++; $display("FAIL rmid_second: got %h/%b expected 60/1000", got_q[1], got_g[1]); end
    end
  endtask

  task automatic test_hold();
    bit ok;
    clear_got();
    src_q[1].push_back({1'b0, 8'h70});
    src_q[2].push_back({1'b1, 8'h80});
    wait_got(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_start: got timeout expected 1 byte"); end
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #2;
      checks++;
      if (grant !== 4'b0010 || timeout_err !== 1'b0 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL timeout_idle%0d: got grant %b err %b valid %b expected 0010 0 0", k, grant, timeout_err, tx_valid);
      end
    end
    @(negedge clk); #2;
    checks++; if (timeout_err !== 1'b1 || grant !== 4'b0000) begin failures++; $display("FAIL timeout_pulse: got err %b grant %b expected 1 0000", timeout_err, grant); end
    @(negedge clk); #2;
    checks++; if (timeout_err !== 1'b0 || grant !== 4'b0100) begin failures++; $display("FAIL timeout_next: got err %b grant %b expected 0 0100", timeout_err, grant); end
    wait_drain(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 2 || got_q[got_q.size()-1] !== 8'h80) begin failures++; $display("FAIL timeout_seq: got %0d bytes expected 70,80", got_q.size()); end
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #2;
      checks++;
      if (grant !== 4'b0010 || timeout_err !== 1'b0 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got grant %b err %b valid %b expected 0010 0 0", k, grant, timeout_err, tx_valid);
      end
    end
    src_q[1].push_back({1'b1, 8'h7F});
    wait_drain(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_drain: got timeout expected idle"); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL hold_count: got %0d expected 3", got_q.size()); end
    if (got_q.size() == 3) begin
      checks++;
      if (got_q[0] !== 8'h70 || got_q[1] !== 8'h7F || got_q[2] !== 8'h80 || got_g[2] !== 4'b0100) begin
        failures++;
        $display("FAIL hold_seq: got %h %h %h/%b expected 70 7f 80/0100", got_q[0], got_q[1], got_q[2], got_g[2]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_interleave();
    test_reset_mid();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the mid-packet idle limit in clk cycles, used only when timeout is compiled in.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_data, input, NUM_REQ*8, one byte per requester; requester i uses bits [8i+7:8i].
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, byte-valid per requester.
REQ-007 The block SHALL have port req_last, input, NUM_REQ, end-of-packet flag qualified by req_valid.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ, byte-accepted per requester.
REQ-009 The block SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-010 The block SHALL have port tx_valid, output, 1, tx_data valid.
REQ-011 The block SHALL have port tx_ready, input, 1, UART transmitter can accept a byte.
REQ-012 The block SHALL have port grant, output, NUM_REQ, one-hot current owner; zero when idle.
REQ-013 The block SHALL have port timeout_err, output, 1, single-cycle pulse on forced release; constant 0 when timeout is compiled out.

Function
REQ-014 The block SHALL implement states IDLE and BUSY.
REQ-015 In IDLE with any req_valid high, the block SHALL select a requester round-robin, starting from the index after the last owner, and enter BUSY on the next edge.
REQ-016 Arbitration latency SHALL be exactly one cycle from req_valid rising in IDLE to grant asserted.
REQ-017 In BUSY, tx_data and tx_valid SHALL combinationally follow the owner's req_data and req_valid.
REQ-018 req_ready[i] SHALL equal (BUSY and owner==i and tx_ready); it SHALL be 0 for all others.
REQ-019 A byte transfers when tx_valid and tx_ready are both high.
REQ-020 Grant SHALL be held across the whole packet.
REQ-021 On a transfer with the owner's req_last high, the block SHALL return to IDLE and set the round-robin pointer to owner+1 mod NUM_REQ.
REQ-022 After a packet ends, the block SHALL insert one idle bubble; other requests pending at the last transfer are arbitrated in the following IDLE cycle.
REQ-023 Non-owner requesters SHALL never be acknowledged, and their data SHALL never appear on tx_data.
REQ-024 The owner may deassert req_valid mid-packet; the block SHALL stay in BUSY with tx_valid low.
REQ-025 In IDLE, tx_valid SHALL be 0 and tx_data SHALL be 8'h00.

Reset
REQ-026 While rst_n is low, the block SHALL force state=IDLE, grant=0, pointer=0, timeout counter=0, and timeout_err=0, regardless of clk.
REQ-027 On reset asserted mid-packet, the block SHALL abort the packet and drop the partial byte stream; no resume is attempted.
REQ-028 On reset release, the first arbitration SHALL favour requester 0.

Configuration
REQ-029 With macro UART_TX_ARB_TIMEOUT_EN defined, the block SHALL count consecutive BUSY cycles without a transfer.
REQ-030 The counter SHALL clear on every transfer.
REQ-031 When the count reaches TIMEOUT_CYCLES, the block SHALL pulse timeout_err for one cycle, go to IDLE, and advance the pointer past the owner.
REQ-032 Without UART_TX_ARB_TIMEOUT_EN, the block SHALL contain no counter, tie timeout_err to 0, and hold the grant indefinitely.

Structure
REQ-033 Package uart_tx_arb_pkg SHALL hold the state enum (IDLE, BUSY), the byte width constant (8), and the maximum NUM_REQ constant.
REQ-034 Round-robin selection SHALL be a sub-module rr_picker: inputs request vector and pointer; outputs one-hot pick and index; purely combinational.

Verification
REQ-035 Single requester: req 1 sends 3 bytes 0x41,0x42,0x0A with last on 0x0A -> grant=4'b0010 one cycle later, tx_data sequence 41,42,0A, then IDLE.
REQ-036 Contention: reqs 0 and 2 valid simultaneously after reset -> req 0 packet first, one bubble, then req 2; next contention among 0 and 2 grants req 2 first.
REQ-037 Backpressure: tx_ready held low 5 cycles mid-packet -> tx_data stable, req_ready all 0, no byte lost or duplicated.
REQ-038 Interleave check: req 3 valid throughout req 1's 4-byte packet -> no req 3 byte on tx_data until req 1's last transfer.
REQ-039 Reset mid-packet: rst_n low after 2 of 4 bytes -> grant=0 and tx_valid=0 immediately; after release, requester 0 is favoured.
REQ-040 Timeout (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): owner drops req_valid mid-packet -> timeout_err high exactly one cycle at idle cycle 16, then next requester granted.
